// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with valid/ready handshake and 1-entry skid buffer
//
// Parameters : XLEN (32|64) immediate width, PASS_PC_TAG (1 carries tag_in, 0 ties tag_out low),
//              TAG_W sideband width.
// Ports      : clk, rst (sync, active high), flush (sync, drops all held entries);
//              in_valid/in_ready/instr/ext_op/tag_in  - producer side, in_ready is registered;
//              out_valid/out_ready/imm_out/imm_type/tag_out - consumer side, all registered.
// ext_op     : 0 NONE, 1 I, 2 I_SHAMT, 3 S, 4 B, 5 U, 6 J, 7 CSR_ZIMM.
// Option     : define IMM_AUTO_DECODE_EN to ignore ext_op and derive the type from instr[6:0].
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit PASS_PC_TAG = 1'b1,
  parameter int TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type,
  output logic [TAG_W-1:0] tag_out
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state;
  logic [2:0] op;
  logic [XLEN-1:0] imm;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0] k_imm;
  logic [2:0] k_type;
  logic [TAG_W-1:0] k_tag;
  logic in_xfer, out_xfer;
`ifdef IMM_AUTO_DECODE_EN
  logic [6:0] opc;
  logic unused_ext;
  assign opc = instr[6:0];
  assign unused_ext = ^ext_op;
  // funct3 of 001/101 (SLLI/SRLI/SRAI) is exactly funct3[1:0] == 01
  assign op = (opc == 7'b0010011) ? ((instr[13:12] == 2'b01) ? 3'd2 : 3'd1) :
              (opc == 7'b0000011 || opc == 7'b1100111) ? 3'd1 :
              (opc == 7'b0100011) ? 3'd3 :
              (opc == 7'b1100011) ? 3'd4 :
              (opc == 7'b0110111 || opc == 7'b0010111) ? 3'd5 :
              (opc == 7'b1101111) ? 3'd6 :
              (opc == 7'b1110011) ? (instr[14] ? 3'd7 : 3'd1) : 3'd0;
`else
  logic unused_opc;
  assign unused_opc = ^instr[6:0];
  assign op = ext_op;
`endif
  always_comb
    case (op)
      3'd1: imm = XLEN'($signed(instr[31:20]));
      3'd2: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      3'd3: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'd4: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'd5: imm = XLEN'($signed({instr[31:12], 12'b0}));
      3'd6: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'd7: imm = XLEN'(instr[19:15]);
      default: imm = '0;
    endcase
  assign tag = PASS_PC_TAG ? tag_in : '0;
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  // M is the output register itself; K only fills when M is stalled and a new entry arrives
  always_ff @(posedge clk)
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      imm_out <= '0;
      imm_type <= '0;
      tag_out <= '0;
      k_imm <= '0;
      k_type <= '0;
      k_tag <= '0;
    end else if (flush) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else
      case (state)
        EMPTY:
          if (in_xfer) begin
            state <= ONE;
            out_valid <= 1'b1;
            imm_out <= imm;
            imm_type <= op;
            tag_out <= tag;
          end
        ONE:
          if (in_xfer && !out_xfer) begin
            state <= TWO;
            in_ready <= 1'b0;
            k_imm <= imm;
            k_type <= op;
            k_tag <= tag;
          end else if (in_xfer) begin
            imm_out <= imm;
            imm_type <= op;
            tag_out <= tag;
          end else if (out_xfer) begin
            state <= EMPTY;
            out_valid <= 1'b0;
          end
        TWO:
          if (out_xfer) begin
            state <= ONE;
            in_ready <= 1'b1;
            imm_out <= k_imm;
            imm_type <= k_type;
            tag_out <= k_tag;
          end
        default: begin
          state <= EMPTY;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe (XLEN=32, XLEN=64 and no-tag instances)
module tb_imm_gen_pipe;
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_SH = 3'd2, T_S = 3'd3, T_B = 3'd4, T_U = 3'd5, T_J = 3'd6, T_CZ = 3'd7;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0, tag_in = '0;
  logic [2:0] ext_op = '0;
  logic ir32, ov32, ir64, ov64, irnt, ovnt;
  logic [31:0] imm32, tag32, tag64, imm_nt, tagnt;
  logic [63:0] imm64;
  logic [2:0] ty32, ty64, tynt;
  int total = 0, passed = 0, failed = 0;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .ext_op(ext_op), .tag_in(tag_in), .out_valid(ov32), .out_ready(out_ready),
    .imm_out(imm32), .imm_type(ty32), .tag_out(tag32));
  imm_gen_pipe #(.XLEN(64)) u64 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .ext_op(ext_op), .tag_in(tag_in), .out_valid(ov64), .out_ready(out_ready),
    .imm_out(imm64), .imm_type(ty64), .tag_out(tag64));
  imm_gen_pipe #(.XLEN(32), .PASS_PC_TAG(1'b0)) unt (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irnt),
    .instr(instr), .ext_op(ext_op), .tag_in(tag_in), .out_valid(ovnt), .out_ready(out_ready),
    .imm_out(imm_nt), .imm_type(tynt), .tag_out(tagnt));
  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] op, input logic [31:0] t);
    in_valid = v;
    instr = i;
    ext_op = op;
    tag_in = t;
  endtask
  task automatic expect_out(input string nm, input logic ir, input logic [31:0] e32, input logic [63:0] e64,
                            input logic [2:0] ty, input logic [31:0] tg);
    chk({nm, ".ov32"}, 64'(ov32), 64'd1);
    chk({nm, ".ov64"}, 64'(ov64), 64'd1);
    chk({nm, ".ir32"}, 64'(ir32), 64'(ir));
    chk({nm, ".imm32"}, 64'(imm32), 64'(e32));
    chk({nm, ".imm64"}, imm64, e64);
    chk({nm, ".ty32"}, 64'(ty32), 64'(ty));
    chk({nm, ".ty64"}, 64'(ty64), 64'(ty));
    chk({nm, ".tag32"}, 64'(tag32), 64'(tg));
    chk({nm, ".tagnt"}, 64'(tagnt), 64'd0);
  endtask
  task automatic expect_idle(input string nm);
    chk({nm, ".ov32"}, 64'(ov32), 64'd0);
    chk({nm, ".ov64"}, 64'(ov64), 64'd0);
    chk({nm, ".ir32"}, 64'(ir32), 64'd1);
    chk({nm, ".ir64"}, 64'(ir64), 64'd1);
  endtask
  initial begin
    step;
    step;
    expect_idle("reset");
    chk("reset.imm32", 64'(imm32), 64'd0);
    chk("reset.imm64", imm64, 64'd0);
    chk("reset.ty", 64'(ty32), 64'd0);
    chk("reset.tag", 64'(tag32), 64'd0);
    rst = 1'b0;
    drive(1'b1, 32'hFFF00093, T_I, 32'h100);
    step;
    expect_out("i_neg", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, T_I, 32'h100);
    drive(1'b1, 32'h8000006F, T_J, 32'h104);
    step;
    expect_out("j", 1'b1, 32'hFFF00000, 64'hFFFFFFFFFFF00000, T_J, 32'h104);
    drive(1'b1, 32'h800000B7, T_U, 32'h108);
    step;
    expect_out("u", 1'b1, 32'h80000000, 64'hFFFFFFFF80000000, T_U, 32'h108);
    drive(1'b1, 32'h03F09093, T_SH, 32'h10C);
    step;
    expect_out("shamt", 1'b1, 32'd31, 64'd63, T_SH, 32'h10C);
    drive(1'b1, 32'hFE002E23, T_S, 32'h110);
    step;
    expect_out("s", 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, T_S, 32'h110);
    drive(1'b1, 32'h80000063, T_B, 32'h114);
    step;
    expect_out("b_neg", 1'b1, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, T_B, 32'h114);
    drive(1'b1, 32'h00000463, T_B, 32'h118);
    step;
    expect_out("b_pos", 1'b1, 32'd8, 64'd8, T_B, 32'h118);
    drive(1'b1, 32'h34015073, T_CZ, 32'h11C);
    step;
    expect_out("zimm", 1'b1, 32'd2, 64'd2, T_CZ, 32'h11C);
    drive(1'b1, 32'hFFFFFFFF, T_NONE, 32'h120);
    step;
    expect_out("none", 1'b1, 32'd0, 64'd0, T_NONE, 32'h120);
    drive(1'b1, 32'h7FF00093, T_I, 32'h124);
    step;
    expect_out("i_pos", 1'b1, 32'h7FF, 64'h7FF, T_I, 32'h124);
`ifdef IMM_AUTO_DECODE_EN
    drive(1'b1, 32'h34015073, T_I, 32'h128);
    step;
    expect_out("auto_zimm", 1'b1, 32'd2, 64'd2, T_CZ, 32'h128);
    drive(1'b1, 32'h00000000, T_I, 32'h12C);
    step;
    expect_out("auto_none", 1'b1, 32'd0, 64'd0, T_NONE, 32'h12C);
`endif
    drive(1'b0, 32'h0, T_NONE, 32'h0);
    step;
    expect_idle("drain");
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, T_I, 32'hA);
    step;
    expect_out("bp_a", 1'b1, 32'd1, 64'd1, T_I, 32'hA);
    drive(1'b1, 32'h00200093, T_I, 32'hB);
    step;
    expect_out("bp_b_held", 1'b0, 32'd1, 64'd1, T_I, 32'hA);
    drive(1'b1, 32'h00300093, T_I, 32'hC);
    step;
    expect_out("bp_c_stall", 1'b0, 32'd1, 64'd1, T_I, 32'hA);
    out_ready = 1'b1;
    step;
    expect_out("bp_out_b", 1'b1, 32'd2, 64'd2, T_I, 32'hB);
    step;
    expect_out("bp_out_c", 1'b1, 32'd3, 64'd3, T_I, 32'hC);
    drive(1'b0, 32'h0, T_NONE, 32'h0);
    step;
    expect_idle("bp_empty");
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, T_I, 32'hD0);
    step;
    drive(1'b1, 32'h00500093, T_I, 32'hD1);
    step;
    expect_out("fl_two", 1'b0, 32'd4, 64'd4, T_I, 32'hD0);
    out_ready = 1'b1;
    drive(1'b1, 32'h00600093, T_I, 32'hD2);
    flush = 1'b1;
    step;
    expect_idle("flush");
    flush = 1'b0;
    drive(1'b0, 32'h0, T_NONE, 32'h0);
    step;
    expect_idle("flush_gone");
    drive(1'b1, 32'hFFF00093, T_I, 32'hE0);
    step;
    expect_out("pre_rst", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, T_I, 32'hE0);
    rst = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h8000006F, T_J, 32'hE4);
    step;
    expect_idle("rst_mid");
    chk("rst_mid.imm32", 64'(imm32), 64'd0);
    chk("rst_mid.imm64", imm64, 64'd0);
    chk("rst_mid.ty", 64'(ty32), 64'd0);
    chk("rst_mid.tag", 64'(tag32), 64'd0);
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, T_NONE, 32'h0);
    step;
    expect_idle("post_rst");
    drive(1'b1, 32'h800000B7, T_U, 32'hE8);
    step;
    expect_out("recover", 1'b1, 32'h80000000, 64'hFFFFFFFF80000000, T_U, 32'hE8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
